// File: rtl/xy_mesh_pmu_if.sv
// ============================================================================
// Module   : xy_mesh_pmu_if
// Function : Observed AXI handshake bus plus register read port of the mesh PMU
// Revision : 1.0
// ============================================================================
`default_nettype none

interface xy_mesh_pmu_if #(
    parameter int NUM_PORTS = 9,
    parameter int CNT_WIDTH = 32
);
    localparam int ADDR_W = $clog2(NUM_PORTS*10+1);

    logic [NUM_PORTS*5-1:0] hs_valid_i;
    logic [NUM_PORTS*5-1:0] hs_ready_i;
    logic                   rd_en_i;
    logic [ADDR_W-1:0]      rd_addr_i;
    logic [CNT_WIDTH-1:0]   rd_data_o;
    logic                   rd_valid_o;

    modport master (
        output hs_valid_i, hs_ready_i, rd_en_i, rd_addr_i,
        input  rd_data_o, rd_valid_o
    );

    modport slave (
        input  hs_valid_i, hs_ready_i, rd_en_i, rd_addr_i,
        output rd_data_o, rd_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/xy_mesh_pmu.sv
// ============================================================================
// Module   : xy_mesh_pmu
// Function : Per-port/per-channel handshake and stall counters with windowed
//            snapshots, read back through a 1-cycle register port
// Revision : 1.0
// ============================================================================
`default_nettype none

module xy_mesh_pmu #(
    parameter int NUM_PORTS    = 9,
    parameter int CNT_WIDTH    = 32,
    parameter int WINDOW_WIDTH = 16
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    enable_i,
    input  wire logic                    clear_i,
    input  wire logic [WINDOW_WIDTH-1:0] window_len_i,
    xy_mesh_pmu_if.slave                 bus,
    output logic                         window_done_o,
    output logic [NUM_PORTS-1:0]         overflow_o
);

    localparam int ADDR_W   = $clog2(NUM_PORTS*10+1);
    localparam int NUM_CNT  = NUM_PORTS*5;
    localparam int OVF_BITS = (NUM_PORTS < CNT_WIDTH) ? NUM_PORTS : CNT_WIDTH;
    localparam logic [ADDR_W-1:0]       OVF_ADDR = ADDR_W'(NUM_PORTS*10);
    localparam logic [CNT_WIDTH-1:0]    CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [WINDOW_WIDTH-1:0] WIN_ONE  = WINDOW_WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;

    logic [CNT_WIDTH-1:0]    live_ev_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]    live_st_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]    snap_ev_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]    snap_st_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]    live_ev_d [NUM_CNT];
    logic [CNT_WIDTH-1:0]    live_st_d [NUM_CNT];
    logic [CNT_WIDTH-1:0]    snap_ev_d [NUM_CNT];
    logic [CNT_WIDTH-1:0]    snap_st_d [NUM_CNT];
    logic [CNT_WIDTH-1:0]    w_ev_nxt  [NUM_CNT];
    logic [CNT_WIDTH-1:0]    w_st_nxt  [NUM_CNT];

    logic [WINDOW_WIDTH-1:0] win_q, win_d;
    logic [NUM_PORTS-1:0]    ovf_q, ovf_d, w_ovf_hit;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    w_run, w_win_en, w_win_end;
    logic [ADDR_W-2:0]       w_idx;
    logic                    w_kind;
    logic [CNT_WIDTH-1:0]    w_ovf_ext, w_rd_word;

    // Saturating increments, computed for every counter each cycle
    always_comb begin
        w_ovf_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int c = 0; c < 5; c++) begin
                w_ev_nxt[p*5+c] = live_ev_q[p*5+c];
                w_st_nxt[p*5+c] = live_st_q[p*5+c];
                if (bus.hs_valid_i[p*5+c] && bus.hs_ready_i[p*5+c] &&
                    (live_ev_q[p*5+c] != CNT_MAX))
                    w_ev_nxt[p*5+c] = live_ev_q[p*5+c] + CNT_ONE;
                if (bus.hs_valid_i[p*5+c] && !bus.hs_ready_i[p*5+c] &&
                    (live_st_q[p*5+c] != CNT_MAX))
                    w_st_nxt[p*5+c] = live_st_q[p*5+c] + CNT_ONE;
                if ((w_ev_nxt[p*5+c] == CNT_MAX) || (w_st_nxt[p*5+c] == CNT_MAX))
                    w_ovf_hit[p] = 1'b1;
            end
        end
    end

    always_comb begin
        w_run     = (state_q == RUN);
        w_win_en  = (window_len_i != '0);
        // >= so a window length shrunk below the current count still closes
        w_win_end = w_run && w_win_en && (win_q >= (window_len_i - WIN_ONE));

        live_ev_d = live_ev_q;
        live_st_d = live_st_q;
        snap_ev_d = snap_ev_q;
        snap_st_d = snap_st_q;
        win_d     = win_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        if (clear_i) begin
            live_ev_d = '{default: '0};
            live_st_d = '{default: '0};
            snap_ev_d = '{default: '0};
            snap_st_d = '{default: '0};
            win_d     = '0;
            ovf_d     = '0;
        end else if (w_win_end) begin
            snap_ev_d = w_ev_nxt;
            snap_st_d = w_st_nxt;
            live_ev_d = '{default: '0};
            live_st_d = '{default: '0};
            win_d     = '0;
            ovf_d     = ovf_q | w_ovf_hit;
            done_d    = 1'b1;
        end else if (w_run) begin
            live_ev_d = w_ev_nxt;
            live_st_d = w_st_nxt;
            win_d     = w_win_en ? (win_q + WIN_ONE) : '0;
            ovf_d     = ovf_q | w_ovf_hit;
        end else if (!w_win_en) begin
            win_d     = '0;
        end
    end

    // Read mux works on the registered banks, so a read racing a snapshot sees old data
    always_comb begin
        w_idx     = bus.rd_addr_i[ADDR_W-1:1];
        w_kind    = bus.rd_addr_i[0];
        w_ovf_ext = '0;
        w_ovf_ext[OVF_BITS-1:0] = ovf_q[OVF_BITS-1:0];
        w_rd_word = '0;
        if (bus.rd_addr_i < OVF_ADDR) begin
            if (w_win_en)
                w_rd_word = w_kind ? snap_st_q[w_idx] : snap_ev_q[w_idx];
            else
                w_rd_word = w_kind ? live_st_q[w_idx] : live_ev_q[w_idx];
        end else if (bus.rd_addr_i == OVF_ADDR) begin
            w_rd_word = w_ovf_ext;
        end
        rd_data_d  = bus.rd_en_i ? w_rd_word : rd_data_q;
        rd_valid_d = bus.rd_en_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            live_ev_q  <= '{default: '0};
            live_st_q  <= '{default: '0};
            snap_ev_q  <= '{default: '0};
            snap_st_q  <= '{default: '0};
            win_q      <= '0;
            ovf_q      <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= enable_i ? RUN : IDLE;
            live_ev_q  <= live_ev_d;
            live_st_q  <= live_st_d;
            snap_ev_q  <= snap_ev_d;
            snap_st_q  <= snap_st_d;
            win_q      <= win_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign window_done_o  = done_q;
    assign overflow_o     = ovf_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_xy_mesh_pmu.sv
// ============================================================================
// Module   : tb_xy_mesh_pmu
// Function : Directed scoreboard bench for xy_mesh_pmu (4-bit counters)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xy_mesh_pmu;

    localparam int NP = 9;
    localparam int CW = 4;
    localparam int WW = 16;
    localparam int AW = $clog2(NP*10+1);

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          clear  = 1'b0;
    logic [WW-1:0] wlen   = '0;
    logic          wdone;
    logic [NP-1:0] ovf;

    xy_mesh_pmu_if #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) bus ();

    xy_mesh_pmu #(
        .NUM_PORTS    (NP),
        .CNT_WIDTH    (CW),
        .WINDOW_WIDTH (WW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable),
        .clear_i       (clear),
        .window_len_i  (wlen),
        .bus           (bus),
        .window_done_o (wdone),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int addr, input int exp);
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = AW'(addr);
        exp_q.push_back(exp);
        addr_q.push_back(addr);
        tick(1);
        bus.rd_en_i   = 1'b0;
    endtask

    task automatic hs(input int b, input logic v, input logic r);
        bus.hs_valid_i[b] = v;
        bus.hs_ready_i[b] = r;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // Monitor: every presented read word is matched against the scoreboard
    always @(negedge clk) begin
        if (bus.rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0)
                chk("rd_unexpected_valid", 32'd1, 32'd0);
            else
                chk($sformatf("rd_addr%0d", addr_q.pop_front()),
                    32'(bus.rd_data_o), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hs_valid_i = '0;
        bus.hs_ready_i = '0;
        bus.rd_en_i    = 1'b0;
        bus.rd_addr_i  = '0;
        tick(2);
        chk("reset_rd_data",  32'(bus.rd_data_o),  32'd0);
        chk("reset_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("reset_wdone",    32'(wdone),          32'd0);
        chk("reset_ovf",      32'(ovf),            32'd0);
        rst = 1'b0;

        // Free-running: 10 handshakes then 4 stalls on port 0 AW
        enable = 1'b1;
        tick(1);
        hs(0, 1'b1, 1'b1); tick(10);
        hs(0, 1'b1, 1'b0); tick(4);
        hs(0, 1'b0, 1'b0);
        rd(0, 10); rd(1, 4); rd(2, 0); rd(44, 0); rd(89, 0); rd(90, 0); rd(100, 0);

        // Window of 8 on port 8 R
        wlen = 16'd8;
        pulse_clear();
        hs(44, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("wdone_w8_cyc%0d", k), 32'(wdone), 32'((k % 8) == 0));
        end
        rd(88, 8);
        hs(44, 1'b0, 1'b0);
        wlen = 16'd0;
        rd(88, 1); rd(89, 0);

        // Enable gap of 5 cycles after window cycle 3, port 4 B
        wlen = 16'd8;
        pulse_clear();
        hs(22, 1'b1, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            if (k == 4) enable = 1'b0;
            if (k == 9) enable = 1'b1;
            if (k == 13) begin
                bus.rd_en_i   = 1'b1;
                bus.rd_addr_i = AW'(44);
                exp_q.push_back(0);
                addr_q.push_back(44);
            end
            @(posedge clk); @(negedge clk);
            bus.rd_en_i = 1'b0;
            chk($sformatf("wdone_gap_cyc%0d", k), 32'(wdone), 32'(k == 13));
        end
        hs(22, 1'b0, 1'b0);
        rd(44, 8); rd(45, 0); rd(88, 0);

        // Saturation on port 2 W
        wlen = 16'd0;
        pulse_clear();
        hs(11, 1'b1, 1'b1); tick(20);
        hs(11, 1'b0, 1'b0);
        chk("ovf_sat", 32'(ovf), 32'h004);
        rd(22, 15); rd(23, 0); rd(90, 4);
        pulse_clear();
        chk("ovf_after_clear", 32'(ovf), 32'd0);
        rd(22, 0); rd(90, 0);

        // Clear coinciding with window end, port 0 AR
        wlen = 16'd4;
        pulse_clear();
        hs(3, 1'b1, 1'b1); tick(3);
        clear = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wdone_clear_at_end", 32'(wdone), 32'd0);
        clear = 1'b0;
        hs(3, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("wdone_clear_next", 32'(wdone), 32'd0);
        rd(6, 0); rd(7, 0);
        wlen = 16'd0;
        rd(6, 0);

        // Asynchronous reset with counts pending, port 1 AW
        pulse_clear();
        hs(5, 1'b1, 1'b1); tick(3);
        hs(5, 1'b0, 1'b0);
        rd(10, 3);
        @(negedge clk);
        #2;
        hs(5, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_data",  32'(bus.rd_data_o),  32'd0);
        chk("async_rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("async_rst_wdone",    32'(wdone),          32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        hs(5, 1'b0, 1'b0);
        rd(10, 0); rd(11, 0);

        tick(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xy_mesh_pmu.md
Name: xy_mesh_pmu

Overview:
Parametrised performance-monitor unit for the XY mesh. It observes the valid/ready pairs of every AXI channel on every mesh port. Per port and channel it counts completed handshakes and stall cycles (valid high, ready low), using a windowed snapshot mechanism. It sits beside the mesh in the CPU/RAM mesh top and is read through a simple register read port.

Parameters:
NUM_PORTS, 9, number of monitored mesh ports (MAX_ROUTERS_X*MAX_ROUTERS_Y)
CNT_WIDTH, 32, width of each event/stall counter
WINDOW_WIDTH, 16, width of the sampling-window length
ADDR_W, $clog2(NUM_PORTS*10+1), read address width (derived, not overridden)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
enable_i  in  1  counting enable
clear_i  in  1  synchronous clear pulse
window_len_i  in  WINDOW_WIDTH  window length in cycles; 0 = free-running
hs_valid_i  in  NUM_PORTS*5  valid per port/channel; bit index port*5+ch; ch order AW=0, W=1, B=2, AR=3, R=4
hs_ready_i  in  NUM_PORTS*5  ready, same indexing
rd_en_i  in  1  read request
rd_addr_i  in  ADDR_W  register address
rd_data_o  out  CNT_WIDTH  read data
rd_valid_o  out  1  read data valid
window_done_o  out  1  one-cycle pulse on snapshot
overflow_o  out  NUM_PORTS  sticky per-port saturation flags

Behaviour:
- Reset (async, rst=1): all live counters, snapshot counters, window counter, overflow flags, rd_data_o, rd_valid_o and window_done_o go to 0. State goes to IDLE.
- FSM states:
  - IDLE: enable_i=0; live counters and window counter hold.
  - RUN: enable_i=1.
  - Transitions follow enable_i each cycle, registered. Dropping enable mid-window freezes the window; it resumes on re-enable.
- In RUN, each cycle, per (port, ch):
  - event counter += 1 if valid&ready;
  - stall counter += 1 if valid&!ready.
- Counters saturate at all-ones; they never wrap. Reaching saturation sets overflow_o[port] (sticky).
- Window (window_len_i != 0):
  - The window counter increments in RUN.
  - When it equals window_len_i-1: the snapshot bank takes the live values including this cycle's increments, live counters and the window counter reset to 0, and window_done_o pulses on the next cycle.
  - window_len_i=1 snapshots every RUN cycle.
- window_len_i==0: no snapshots; window counter held at 0; reads return live counters.
- clear_i:
  - Zeroes live counters, snapshot bank, window counter and overflow flags.
  - Takes priority over same-cycle increments and snapshot; no window_done_o pulse is generated.
  - Works in IDLE and RUN.
- Read port:
  - Address map: addr = (port*5+ch)*2 + kind, where kind 0 = event, 1 = stall. addr = NUM_PORTS*10 returns overflow flags zero-extended. Higher addresses return 0.
  - Source is the snapshot bank when window_len_i!=0, otherwise the live bank.
  - Latency 1: rd_en_i at cycle N gives rd_data_o/rd_valid_o at N+1. rd_valid_o is low otherwise, and rd_data_o holds its last value.
  - A read that coincides with a snapshot returns the pre-snapshot bank value.
  - Back-to-back reads are supported every cycle.
- Reset mid-window discards all counts; no window_done_o pulse.

Test Plan:
- Reset, enable=1, window_len=0; port 0 AW valid=ready=1 for 10 cycles, then valid=1, ready=0 for 4 cycles; read addr 0 and 1 -> 10 and 4; all other addrs 0.
- window_len=8; port 8 R handshake every cycle -> window_done_o pulses every 8 cycles; read addr 8*10+8 -> 8; live bank restarts from 0.
- Toggle enable low for 5 cycles at window cycle 3 with window_len=8 -> snapshot occurs 13 cycles after start; count = 8 handshakes.
- CNT_WIDTH=4; port 2 W handshake 20 cycles -> event counter 15, overflow_o[2]=1, addr NUM_PORTS*10 reads 0x004; clear_i -> all 0, overflow_o=0.
- clear_i in the same cycle as window end with handshakes active -> no window_done_o, all counters 0 next cycle.
- Assert rst during RUN with counts pending -> outputs 0 immediately (async), FSM IDLE, reads return 0.
